// File: rtl/b1_corr_bank.sv
// Multi-tap I/Q correlator bank: coherent integration over PRN periods, saturating dump, one tap per transfer.
// Latency: dump boundary sop sampled at edge k -> tap 0 valid in cycle k+1, then one tap per accepted cycle.
// Backpressure: words hold while valid && !ready; a boundary arriving mid-send is dropped (tx_drop pulse).
//
// Ports:
//   rx_clk / rx_rst        : clock, asynchronous active-low reset
//   rx_src_real/imag       : signed baseband samples, rx_loc_boc per-tap negate bits
//   rx_prn_sop             : first sample of a PRN period
//   cfg_en / cfg_ncoh      : channel enable, PRN periods per dump (0 behaves as 1)
//   tx_dump_*              : ready/valid dump port, one tap per transfer, last on final tap
//   tx_epoch_cnt           : saturating count of completed dumps
//   tx_ovf / tx_drop       : sticky saturation flag, single-cycle drop pulse
module b1_corr_bank #(
    parameter int IW     = 16,
    parameter int AW     = 30,
    parameter int SHIFT  = 6,
    parameter int OW     = 24,
    parameter int N_TAP  = 5,
    parameter int NCOH_W = 5,
    parameter int TAP_W  = 3
) (
    input  logic                rx_clk,
    input  logic                rx_rst,
    input  logic [IW-1:0]       rx_src_real,
    input  logic [IW-1:0]       rx_src_imag,
    input  logic [N_TAP-1:0]    rx_loc_boc,
    input  logic                rx_prn_sop,
    input  logic                cfg_en,
    input  logic [NCOH_W-1:0]   cfg_ncoh,
    output logic                tx_dump_valid,
    input  logic                tx_dump_ready,
    output logic [TAP_W-1:0]    tx_dump_tap,
    output logic [OW-1:0]       tx_dump_real,
    output logic [OW-1:0]       tx_dump_imag,
    output logic                tx_dump_last,
    output logic [31:0]         tx_epoch_cnt,
    output logic                tx_ovf,
    output logic                tx_drop
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IW-1:0]        IN_MIN  = {1'b1, {(IW-1){1'b0}}};
    localparam logic [IW-1:0]        IN_MAX  = ~IN_MIN;
    localparam logic [OW-1:0]        OUT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]        OUT_MIN = ~OUT_MAX;
    localparam logic signed [AW-1:0] SAT_HI  = {{(AW-OW){1'b0}}, OUT_MAX};
    localparam logic signed [AW-1:0] SAT_LO  = ~SAT_HI;
    localparam logic [TAP_W-1:0]     LAST_TAP = TAP_W'(N_TAP-1);

    // Negating the most negative sample clamps to the most positive one.
    function automatic logic [AW-1:0] prod(input logic [IW-1:0] x, input logic neg);
        logic [IW-1:0] p;
        p = x;
        if (neg) p = (x == IN_MIN) ? IN_MAX : -x;
        return {{(AW-IW){p[IW-1]}}, p};
    endfunction

    // Returns {saturated_flag, value}: drop SHIFT LSBs, clamp to signed OW range.
    function automatic logic [OW:0] sat(input logic [AW-1:0] a);
        logic signed [AW-1:0] sh;
        sh = $signed(a) >>> SHIFT;
        if (sh > SAT_HI)      return {1'b1, OUT_MAX};
        else if (sh < SAT_LO) return {1'b1, OUT_MIN};
        else                  return {1'b0, sh[OW-1:0]};
    endfunction

    logic [AW-1:0]     acc_re [N_TAP];
    logic [AW-1:0]     acc_im [N_TAP];
    logic [AW-1:0]     p_re   [N_TAP];
    logic [AW-1:0]     p_im   [N_TAP];
    logic [OW:0]       s_re   [N_TAP];
    logic [OW:0]       s_im   [N_TAP];
    logic [OW-1:0]     buf_re [N_TAP];
    logic [OW-1:0]     buf_im [N_TAP];
    logic [NCOH_W-1:0] cnt;
    logic [NCOH_W-1:0] ncoh_q;
    logic [NCOH_W-1:0] ncoh_eff;
    logic              aligned;
    logic              boundary;
    logic              ovf_hit;
    state_t            state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic              load;
    logic              drop_d;

    assign ncoh_eff = (cfg_ncoh == '0) ? NCOH_W'(1) : cfg_ncoh;
    // The accumulators at a boundary hold exactly ncoh periods; the current sample starts the next one.
    assign boundary = cfg_en && aligned && rx_prn_sop && (cnt == ncoh_q);

    always_comb begin
        ovf_hit = 1'b0;
        for (int t = 0; t < N_TAP; t++) begin
            p_re[t] = prod(rx_src_real, rx_loc_boc[t]);
            p_im[t] = prod(rx_src_imag, rx_loc_boc[t]);
            s_re[t] = sat(acc_re[t]);
            s_im[t] = sat(acc_im[t]);
            ovf_hit = ovf_hit | s_re[t][OW] | s_im[t][OW];
        end
    end

    // Integration: the first sop after reset/enable only aligns; later sops either dump or count.
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            for (int t = 0; t < N_TAP; t++) begin
                acc_re[t] <= '0;
                acc_im[t] <= '0;
            end
            cnt     <= '0;
            ncoh_q  <= '0;
            aligned <= 1'b0;
        end else if (!cfg_en) begin
            for (int t = 0; t < N_TAP; t++) begin
                acc_re[t] <= '0;
                acc_im[t] <= '0;
            end
            cnt     <= '0;
            aligned <= 1'b0;
        end else if (rx_prn_sop && (!aligned || cnt == ncoh_q)) begin
            for (int t = 0; t < N_TAP; t++) begin
                acc_re[t] <= p_re[t];
                acc_im[t] <= p_im[t];
            end
            cnt     <= NCOH_W'(1);
            ncoh_q  <= ncoh_eff;
            aligned <= 1'b1;
        end else if (aligned) begin
            for (int t = 0; t < N_TAP; t++) begin
                acc_re[t] <= acc_re[t] + p_re[t];
                acc_im[t] <= acc_im[t] + p_im[t];
            end
            if (rx_prn_sop) cnt <= cnt + NCOH_W'(1);
        end
    end

    // Output FSM next state. A boundary landing on acceptance of the last tap reloads
    // the buffer and restarts at tap 0 rather than dropping.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        load    = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (boundary) begin
                    load    = 1'b1;
                    state_d = SEND;
                    tap_d   = '0;
                end
            end
            SEND: begin
                if (tx_dump_ready) begin
                    if (tap_q == LAST_TAP) begin
                        tap_d = '0;
                        if (boundary) load = 1'b1;
                        else          state_d = IDLE;
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
                if (boundary && !(tx_dump_ready && tap_q == LAST_TAP)) drop_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            state_q      <= IDLE;
            tap_q        <= '0;
            tx_drop      <= 1'b0;
            tx_ovf       <= 1'b0;
            tx_epoch_cnt <= '0;
            for (int t = 0; t < N_TAP; t++) begin
                buf_re[t] <= '0;
                buf_im[t] <= '0;
            end
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            tx_drop <= drop_d;
            if (boundary && tx_epoch_cnt != 32'hFFFF_FFFF) tx_epoch_cnt <= tx_epoch_cnt + 32'd1;
            if (load) begin
                for (int t = 0; t < N_TAP; t++) begin
                    buf_re[t] <= s_re[t][OW-1:0];
                    buf_im[t] <= s_im[t][OW-1:0];
                end
                if (ovf_hit) tx_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        tx_dump_real = '0;
        tx_dump_imag = '0;
        for (int t = 0; t < N_TAP; t++) begin
            if (tap_q == TAP_W'(t)) begin
                tx_dump_real = buf_re[t];
                tx_dump_imag = buf_im[t];
            end
        end
    end

    assign tx_dump_valid = (state_q == SEND);
    assign tx_dump_tap   = tap_q;
    assign tx_dump_last  = (state_q == SEND) && (tap_q == LAST_TAP);

endmodule

// File: doc/b1_corr_bank.md
# b1_corr_bank

Parametrised multi-tap I/Q correlator bank for the B1 tracking channel. It replaces fixed E/P/L correlation with N_TAP taps, coherent integration over a configurable number of PRN periods, saturating arithmetic and a ready/valid dump port. It sits between the baseband mixer/code NCO, which supply the samples, the per-tap BOC replica bits and the PRN start pulse, and the discriminator/loop-filter stage, which consumes one tap per transfer.

## Interface
- IW, 16, input sample width (signed)
- AW, 30, accumulator width (signed)
- SHIFT, 6, LSBs dropped at dump
- OW, 24, dump word width (signed); AW-SHIFT >= OW
- N_TAP, 5, correlator taps (tap 0 = earliest)
- NCOH_W, 5, width of coherent-period count
- TAP_W, 3, tap index width; 2**TAP_W >= N_TAP
- rx_clk  in  1  single clock, all logic on rising edge
- rx_rst  in  1  reset; asynchronous assert, active-low
- rx_src_real  in  IW  baseband I sample
- rx_src_imag  in  IW  baseband Q sample
- rx_loc_boc  in  N_TAP  per-tap replica bit; 1 = negate sample
- rx_prn_sop  in  1  marks the first sample of a PRN period
- cfg_en  in  1  channel enable
- cfg_ncoh  in  NCOH_W  PRN periods per dump; 0 treated as 1
- tx_dump_valid  out  1  dump word valid
- tx_dump_ready  in  1  consumer accepts word
- tx_dump_tap  out  TAP_W  tap index of current word
- tx_dump_real  out  OW  tap I result
- tx_dump_imag  out  OW  tap Q result
- tx_dump_last  out  1  high with tap N_TAP-1
- tx_epoch_cnt  out  32  completed dumps, saturating
- tx_ovf  out  1  sticky: a dump word saturated
- tx_drop  out  1  one-cycle pulse: dump lost to backpressure

## Operation
- Per tap t: if rx_loc_boc[t]=1, product = -sample, else product = sample. Negating -2^(IW-1) yields +2^(IW-1)-1. The product is sign-extended to AW.
- Accumulators are 2*N_TAP AW-bit registers. They wrap and do not saturate.
- Alignment. After reset or cfg_en rising, the bank is unaligned. The first rx_prn_sop loads each accumulator with the current product, sets the period count to 1, latches ncoh = max(cfg_ncoh,1) and sets the aligned flag. No dump occurs on this pulse.
- On a later rx_prn_sop with count == ncoh, this is a dump boundary:
  - The accumulator value, which excludes the current sample, is written to the dump buffer as acc[AW-1:SHIFT].
  - That value saturates to the signed OW range. Any saturation sets tx_ovf.
  - Accumulators reload with the current product, count resets to 1, ncoh is re-latched and tx_epoch_cnt increments. tx_epoch_cnt holds at 0xFFFFFFFF.
- On rx_prn_sop with count < ncoh: the sample is accumulated and count increments.
- Non-sop sample: the product is accumulated.
- cfg_en=0: accumulators and count clear and hold, and the bank becomes unaligned. A pending output transfer still completes.
- Output FSM has two states, IDLE and SEND.
  - IDLE: on a dump boundary, load the buffer, set tap index 0, go to SEND.
  - SEND: assert valid and present buffer[tap]. On valid&&ready, increment tap. On acceptance of tap N_TAP-1, go to IDLE.
- Dump boundary while in SEND:
  - Normally the new data is discarded, the buffer stays unchanged, tx_drop pulses and the epoch counter still increments.
  - Exception: if the boundary coincides with acceptance of the last tap, the buffer loads and the FSM stays in SEND at tap 0. No drop occurs.
- Outputs must not change while valid=1 and ready=0.

## Timing
- Reset (rx_rst low, asynchronous):
  - All accumulators, the buffer, count and tx_epoch_cnt are 0.
  - FSM is IDLE, unaligned.
  - tx_dump_valid, tx_dump_last, tx_ovf and tx_drop are 0. tx_dump_tap is 0.
  - Reset mid-SEND deasserts valid immediately.
- Dump boundary sop sampled at edge k: buffer and epoch count update at edge k. Valid with tap 0 is high in cycle k+1.
- tx_drop is high for the single cycle following edge k.
- With ready held high, the N_TAP words occupy N_TAP consecutive cycles. A period of at least N_TAP+1 samples never drops.
- tx_dump_last = valid && tap == N_TAP-1.

## Test plan
- Defaults with N_TAP=3, I=100, Q=-50, boc=0, sop every 64 cycles, cfg_ncoh=1, ready=1:
  - First sop produces no dump.
  - Each later dump gives taps 0..2 = (100, -50), valid in 3 consecutive cycles, last on tap 2.
  - epoch_cnt increments by 1 per dump.
- Same setup with rx_loc_boc=3'b010 → tap 1 = (-100, 50); taps 0 and 2 = (100, -50).
- cfg_ncoh=4 → a dump every 256 samples with (400, -200). cfg_ncoh=0 behaves as 1.
- I=-32768, boc=1, 64-sample period → I=32767, tx_ovf=0. With OW=16 and I=32767, cfg_ncoh=4 → I saturates to 32767 and tx_ovf=1 sticky.
- Ready low across a second dump boundary:
  - tx_drop pulses once, buffer retains the first dump and epoch_cnt=2.
  - Raising ready releases the first dump's words in order.
  - A boundary on the same cycle tap 2 is accepted restarts at tap 0 with the new data and no drop.
- rx_rst pulsed low mid-SEND → valid=0 and epoch_cnt=0 immediately. After release, the first sop only aligns; a dump appears one period later.
